extremum_finder_mc: RTL

Multi-channel, parametrised successor to the single-channel extremum finder. It accepts packed per-channel samples on an AXI4-Stream slave and tracks the per-channel maximum and minimum over windows of 2^EF_log_count accepted beats. Each extremum is scaled by a runtime right shift. One {max,min} result per window goes out on an AXI4-Stream master with full tready back-pressure and overrun detection. Sits between the ADC/filter chain and the DMA/readout path.

---
 rtl/extremum_finder_mc_if.sv | 11 +
 rtl/extremum_finder_mc.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/extremum_finder_mc_if.sv
// AXI4-Stream bundle used for both the sample input and the result output.
interface extremum_finder_mc_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/extremum_finder_mc.sv
// Windowed per-channel max/min tracker with runtime shift and a one-deep
// AXI4-Stream result register that flags dropped windows as overrun.
module extremum_finder_mc_lane #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            beat,
    input  logic            first,
    input  logic            sgn,
    input  logic [5:0]      shift,
    input  logic [DW-1:0]   x,
    output logic [2*DW-1:0] res
);
    logic [DW-1:0] max_q, max_d, min_q, min_d, max_sh, min_sh;
    logic          gt, lt;

    always_comb begin
        gt    = sgn ? ($signed(x) > $signed(max_q)) : (x > max_q);
        lt    = sgn ? ($signed(x) < $signed(min_q)) : (x < min_q);
        max_d = max_q;
        min_d = min_q;
        if (beat) begin
            if (first || gt) max_d = x;
            if (first || lt) min_d = x;
        end
        // Oversized shifts fill with sign (>>>) or zero (>>) by language rules.
        if (sgn) begin
            max_sh = $unsigned($signed(max_d) >>> shift);
            min_sh = $unsigned($signed(min_d) >>> shift);
        end else begin
            max_sh = max_d >> shift;
            min_sh = min_d >> shift;
        end
        res = {max_sh, min_sh};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            min_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end
endmodule

module extremum_finder_mc #(
    parameter int CHANNEL_COUNT = 2,
    parameter int DATA_WIDTH    = 16,
    parameter int COUNT_WIDTH   = 5
) (
    input  logic                   SYS_aclk,
    input  logic                   SYS_aresetn,
    input  logic [COUNT_WIDTH-1:0] EF_log_count,
    input  logic [5:0]             EF_log_shift,
    input  logic                   EF_signed,
    extremum_finder_mc_if.slave    S_AXIS,
    extremum_finder_mc_if.master   M_AXIS,
    output logic                   EF_overrun
);
    localparam int OW = CHANNEL_COUNT * 2 * DATA_WIDTH;

    logic                   rdy_q, rdy_d;
    logic [31:0]            cnt_q, cnt_d, limit;
    logic                   start_q, start_d;
    logic [COUNT_WIDTH-1:0] lc_q, lc_d, lc;
    logic [5:0]             sh_q, sh_d, sh;
    logic                   sg_q, sg_d, sg;
    logic                   vld_q, vld_d, ovr_q, ovr_d;
    logic [OW-1:0]          data_q, data_d;
    logic                   beat, last, stall;
    logic [CHANNEL_COUNT-1:0][2*DATA_WIDTH-1:0] res;

    // The first beat of a window sees the live config; later beats the latched copy.
    assign lc    = start_q ? EF_log_count : lc_q;
    assign sh    = start_q ? EF_log_shift : sh_q;
    assign sg    = start_q ? EF_signed    : sg_q;
    assign beat  = S_AXIS.tvalid && rdy_q;
    assign limit = (32'd1 << lc) - 32'd1;
    assign last  = beat && (cnt_q == limit);
    assign stall = vld_q && !M_AXIS.tready;

    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_lane
        extremum_finder_mc_lane #(.DW(DATA_WIDTH)) u_lane (
            .clk   (SYS_aclk),
            .rst_n (SYS_aresetn),
            .beat  (beat),
            .first (start_q),
            .sgn   (sg),
            .shift (sh),
            .x     (S_AXIS.tdata[c*DATA_WIDTH +: DATA_WIDTH]),
            .res   (res[c])
        );
    end

    always_comb begin
        rdy_d   = 1'b1;
        cnt_d   = cnt_q;
        start_d = start_q;
        lc_d    = lc_q;
        sh_d    = sh_q;
        sg_d    = sg_q;
        vld_d   = vld_q;
        ovr_d   = ovr_q;
        data_d  = data_q;
        if (beat) begin
            cnt_d   = last ? 32'd0 : cnt_q + 32'd1;
            start_d = last;
            if (start_q) begin
                lc_d = EF_log_count;
                sh_d = EF_log_shift;
                sg_d = EF_signed;
            end
        end
        if (vld_q && M_AXIS.tready) vld_d = 1'b0;
        // A finished window can only land if the holding register frees up this cycle.
        if (last) begin
            if (stall) begin
                ovr_d = 1'b1;
            end else begin
                vld_d  = 1'b1;
                data_d = res;
            end
        end
    end

    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
            start_q <= 1'b1;
            lc_q    <= '0;
            sh_q    <= '0;
            sg_q    <= 1'b0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            lc_q    <= lc_d;
            sh_q    <= sh_d;
            sg_q    <= sg_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            data_q  <= data_d;
        end
    end

    assign S_AXIS.tready = rdy_q;
    assign M_AXIS.tvalid = vld_q;
    assign M_AXIS.tdata  = data_q;
    assign EF_overrun    = ovr_q;
endmodule
